// File: rtl/dot_product.sv
// Pipelined unsigned dot product: a registered multiplier bank feeding a
// registered binary adder tree, one new A/B pair accepted every clock.
module dot_product #(
  parameter  int DIM          = 10,
  parameter  int A_DATA_WIDTH = 16,
  parameter  int B_DATA_WIDTH = 16,
  localparam int RES_WIDTH    = A_DATA_WIDTH + B_DATA_WIDTH + $clog2(DIM)
) (
  input  logic                           Clock,
  input  logic                           Reset_n,
  input  logic [A_DATA_WIDTH*DIM-1:0]    A,
  input  logic [B_DATA_WIDTH*DIM-1:0]    B,
  output logic [RES_WIDTH-1:0]           DotProduct
);

  localparam int PROD_WIDTH = A_DATA_WIDTH + B_DATA_WIDTH;
  localparam int LEVELS     = $clog2(DIM);

  // Operand count at a given tree level; level 0 is the product register.
  function automatic int lvl_cnt(input int lvl);
    int n;
    n = DIM;
    for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
    return n;
  endfunction

  // Each level grows by one bit, never beyond the final result width.
  function automatic int lvl_width(input int lvl);
    return (PROD_WIDTH + lvl > RES_WIDTH) ? RES_WIDTH : PROD_WIDTH + lvl;
  endfunction

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = lvl_cnt(l);
    localparam int W = lvl_width(l);

    logic [W-1:0] sum_d [N];
    logic [W-1:0] sum_q [N];

    if (l == 0) begin : g_mul
      always_comb begin
        sum_d = '{default: '0};
        for (int i = 0; i < N; i++) begin
          sum_d[i] = W'(A[i*A_DATA_WIDTH +: A_DATA_WIDTH]) *
                     W'(B[i*B_DATA_WIDTH +: B_DATA_WIDTH]);
        end
      end
    end else begin : g_add
      localparam int NI    = lvl_cnt(l - 1);
      localparam int PAIRS = NI / 2;

      always_comb begin
        sum_d = '{default: '0};
        for (int j = 0; j < PAIRS; j++) begin
          sum_d[j] = W'(g_lvl[l-1].sum_q[2*j]) + W'(g_lvl[l-1].sum_q[2*j+1]);
        end
        // An odd leftover operand rides through this level unchanged.
        if (NI % 2 == 1) begin
          sum_d[N-1] = W'(g_lvl[l-1].sum_q[NI-1]);
        end
      end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
        for (int k = 0; k < N; k++) sum_q[k] <= '0;
      end else begin
        for (int k = 0; k < N; k++) sum_q[k] <= sum_d[k];
      end
    end
  end

  assign DotProduct = RES_WIDTH'(g_lvl[LEVELS].sum_q[0]);

endmodule

// File: tb/tb_dot_product.sv
// Directed bench for dot_product at default parameters (DIM=10, 16x16 bits).
module tb_dot_product;
  localparam int DIM = 10;
  localparam int AW  = 16;
  localparam int BW  = 16;
  localparam int RW  = 36;
  localparam int L   = 5;

  logic                Clock = 1'b0;
  logic                Reset_n = 1'b0;
  logic [AW*DIM-1:0]   A = '0;
  logic [BW*DIM-1:0]   B = '0;
  logic [RW-1:0]       DotProduct;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [AW*DIM-1:0] a;
    logic [BW*DIM-1:0] b;
    logic [RW-1:0]     expv;
    string             name;
  } vec_t;

  vec_t            vecs [7];
  logic [RW-1:0]   exp_q [$];

  dot_product #(.DIM(DIM), .A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .A         (A),
    .B         (B),
    .DotProduct(DotProduct)
  );

  always #5 Clock = ~Clock;

  // ---------------- driver helpers ----------------
  function automatic logic [AW*DIM-1:0] fill(input int v);
    logic [AW*DIM-1:0] r;
    r = '0;
    for (int i = 0; i < DIM; i++) r[i*AW +: AW] = AW'(v);
    return r;
  endfunction

  function automatic logic [AW*DIM-1:0] ramp();
    logic [AW*DIM-1:0] r;
    r = '0;
    for (int i = 0; i < DIM; i++) r[i*AW +: AW] = AW'(i + 1);
    return r;
  endfunction

  // One rising edge, returning on the following falling edge.
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  initial begin
    vecs[0] = '{fill(8),     fill(8),     36'd640,         "all_eights"};
    vecs[1] = '{fill(0),     fill(0),     36'd0,           "zero"};
    vecs[2] = '{fill(65535), fill(65535), 36'd42948362250, "maximum"};
    vecs[3] = '{ramp(),      fill(1),     36'd55,          "ramp_x_ones"};
    vecs[4] = '{fill(1),     ramp(),      36'd55,          "ones_x_ramp"};
    vecs[5] = '{ramp(),      ramp(),      36'd385,         "ramp_x_ramp"};
    vecs[6] = '{fill(2),     fill(3),     36'd60,          "twos_x_threes"};

    // Reset held with live inputs: output must stay 0.
    A = fill(8);
    B = fill(8);
    @(negedge Clock);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("in_reset", DotProduct, '0);
    end

    // First sample after release: 0 for L-1 edges, result on edge L.
    Reset_n = 1'b1;
    for (int k = 1; k < L; k++) begin
      tick();
      check($sformatf("latency_edge%0d", k), DotProduct, '0);
    end
    tick();
    check("first_result", DotProduct, 36'd640);
    tick();
    check("first_result_hold", DotProduct, 36'd640);

    // Table vectors, each held for L edges then for one more.
    foreach (vecs[v]) begin
      A = vecs[v].a;
      B = vecs[v].b;
      repeat (L) tick();
      check(vecs[v].name, DotProduct, vecs[v].expv);
      tick();
      check({vecs[v].name, "_hold"}, DotProduct, vecs[v].expv);
    end

    // Same vectors streamed back-to-back, one per cycle.
    for (int c = 0; c < 7 + L - 1; c++) begin
      if (c < 7) begin
        A = vecs[c].a;
        B = vecs[c].b;
        exp_q.push_back(vecs[c].expv);
      end
      tick();
      if (c >= L - 1) begin
        check($sformatf("stream%0d", c - (L - 1)), DotProduct, exp_q.pop_front());
      end
    end

    // Eights, ones, twos on consecutive cycles.
    A = fill(8); B = fill(8); tick();
    A = fill(1); B = fill(1); tick();
    A = fill(2); B = fill(2); tick();
    A = fill(0); B = fill(0); tick();
    tick();
    check("b2b_eights", DotProduct, 36'd640);
    tick();
    check("b2b_ones", DotProduct, 36'd10);
    tick();
    check("b2b_twos", DotProduct, 36'd40);

    // Reset mid-flight: output clears at once, in-flight eights never emerge.
    A = fill(1); B = fill(1);
    repeat (L + 1) tick();
    check("pre_reset_ones", DotProduct, 36'd10);
    A = fill(8); B = fill(8);
    tick();
    tick();
    @(posedge Clock);
    #2 Reset_n = 1'b0;
    #1 check("async_clear", DotProduct, '0);
    @(negedge Clock);
    A = fill(0); B = fill(0);
    tick();
    check("reset_low_hold", DotProduct, '0);
    Reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("post_reset%0d", k), DotProduct, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
